// File: rtl/udp_pkg.sv
// Shared types and constants for the UDP temperature-frame transmit scheduler.
package udp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    SEND,
    GAP
  } state_e;

  localparam logic [15:0] DATA_INIT   = 16'h2D2D;  // ASCII "--" until the first sample arrives
  localparam int          PKT_LEN_DEF = 64;

endpackage

// File: rtl/udp_tick_gen.sv
// Period counter: asserts tick on the last cycle of every P_PERIOD-cycle slot while enabled.
module udp_tick_gen #(
  parameter int P_PERIOD = 125000000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic tick
);

  localparam int            CW   = (P_PERIOD > 1) ? $clog2(P_PERIOD) : 1;
  localparam logic [CW-1:0] LAST = CW'(P_PERIOD - 1);

  logic [CW-1:0] count;

  // NOTE: non-blocking assignments for all clocked state so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (!enable || count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tick = enable && (count == LAST);

endmodule

// File: rtl/udp_tx_sched.sv
// Periodic frame scheduler for the UDP temperature transmitter: FIFO space check,
// payload hold, packet-end wait with timeout, inter-frame gap and statistics.
module udp_tx_sched
  import udp_pkg::*;
#(
  parameter int          P_PERIOD    = 125000000,
  parameter int          P_TIMEOUT   = 256,
  parameter int          P_GAP       = 12,
  parameter int          P_FIFO_AW   = 11,
  parameter int          P_CNTW      = 16,
  parameter logic [15:0] P_DATA_INIT = DATA_INIT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_enable,
  input  logic              i_clr_stats,
  input  logic              i_sample_valid,
  input  logic [15:0]       i_sample_data,
  input  logic [P_FIFO_AW:0] i_fifo_free,
  input  logic [6:0]        i_pkt_cnt,
  input  logic              i_pkt_end,
  output logic              o_pkt_start,
  output logic [15:0]       o_data_tmp_dec,
  output logic              o_busy,
  output logic [P_CNTW-1:0] o_sent_cnt,
  output logic [P_CNTW-1:0] o_drop_cnt,
  output logic              o_timeout_err
);

  localparam int            FW     = P_FIFO_AW + 1;
  localparam int            TMAX   = (P_TIMEOUT > P_GAP) ? P_TIMEOUT : P_GAP;
  localparam int            TW     = $clog2(TMAX + 1);
  localparam logic [TW-1:0] T_LAST = TW'(P_TIMEOUT - 1);
  localparam logic [TW-1:0] G_LAST = TW'(P_GAP - 1);

  state_e        state;
  logic [TW-1:0] tcnt;
  logic [15:0]   shadow;
  logic          tick;
  logic          space_ok;
  logic          sent_inc;
  logic          drop_inc;
  logic          timeout_hit;

  udp_tick_gen #(
    .P_PERIOD(P_PERIOD)
  ) u_tick_gen (
    .clk   (clk),
    .rst   (rst),
    .enable(i_enable),
    .tick  (tick)
  );

  assign space_ok    = i_fifo_free >= FW'(i_pkt_cnt);
  assign sent_inc    = (state == SEND) && i_pkt_end;
  assign timeout_hit = (state == SEND) && !i_pkt_end && (tcnt == T_LAST);
  // A tick that cannot start a frame, for lack of space or because one is in flight, is a drop.
  assign drop_inc    = tick && !((state == IDLE) && space_ok);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow <= P_DATA_INIT;
    end else if (i_sample_valid) begin
      shadow <= i_sample_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      tcnt           <= '0;
      o_pkt_start    <= 1'b0;
      o_busy         <= 1'b0;
      o_data_tmp_dec <= P_DATA_INIT;
    end else begin
      // NOTE: default first so the start strobe lasts one cycle without a per-state clear.
      o_pkt_start <= 1'b0;
      unique case (state)
        IDLE: begin
          if (tick && space_ok) begin
            state          <= START;
            o_pkt_start    <= 1'b1;
            o_busy         <= 1'b1;
            o_data_tmp_dec <= i_sample_valid ? i_sample_data : shadow;
          end
        end
        START: begin
          state <= SEND;
          tcnt  <= '0;
        end
        SEND: begin
          if (i_pkt_end || tcnt == T_LAST) begin
            state <= GAP;
            tcnt  <= '0;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        GAP: begin
          if (tcnt == G_LAST) begin
            state  <= IDLE;
            o_busy <= 1'b0;
            tcnt   <= '0;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Statistics saturate at all-ones; a clear pulse overrides any same-cycle update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_sent_cnt    <= '0;
      o_drop_cnt    <= '0;
      o_timeout_err <= 1'b0;
    end else if (i_clr_stats) begin
      o_sent_cnt    <= '0;
      o_drop_cnt    <= '0;
      o_timeout_err <= 1'b0;
    end else begin
      if (sent_inc && o_sent_cnt != '1) o_sent_cnt <= o_sent_cnt + 1'b1;
      if (drop_inc && o_drop_cnt != '1) o_drop_cnt <= o_drop_cnt + 1'b1;
      if (timeout_hit) o_timeout_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_udp_tx_sched.sv
// Directed bench for udp_tx_sched: one instance at P_PERIOD=100, a second at P_PERIOD=50 for overruns.
module tb_udp_tx_sched;
  import udp_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        en, en_b, clr, sv, pe, pe_b;
  logic [15:0] sd;
  logic [11:0] ff;
  logic [6:0]  pc;

  logic        a_start, a_busy, a_err;
  logic [15:0] a_data, a_sent, a_drop;
  logic        b_start, b_busy, b_err;
  logic [15:0] b_data, b_sent, b_drop;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  udp_tx_sched #(.P_PERIOD(100)) dut_a (
    .clk(clk), .rst(rst), .i_enable(en), .i_clr_stats(clr),
    .i_sample_valid(sv), .i_sample_data(sd), .i_fifo_free(ff), .i_pkt_cnt(pc),
    .i_pkt_end(pe), .o_pkt_start(a_start), .o_data_tmp_dec(a_data), .o_busy(a_busy),
    .o_sent_cnt(a_sent), .o_drop_cnt(a_drop), .o_timeout_err(a_err)
  );

  udp_tx_sched #(.P_PERIOD(50)) dut_b (
    .clk(clk), .rst(rst), .i_enable(en_b), .i_clr_stats(clr),
    .i_sample_valid(sv), .i_sample_data(sd), .i_fifo_free(ff), .i_pkt_cnt(pc),
    .i_pkt_end(pe_b), .o_pkt_start(b_start), .o_data_tmp_dec(b_data), .o_busy(b_busy),
    .o_sent_cnt(b_sent), .o_drop_cnt(b_drop), .o_timeout_err(b_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Waits (bounded) for a start pulse on instance a or b and checks how many negedges it took.
  task automatic wait_start(input bit use_b, input int budget, input int exp_wait, input string tag);
    int w = 0;
    bit seen = 1'b0;
    while (!seen && w < budget) begin
      @(negedge clk);
      w++;
      seen = use_b ? b_start : a_start;
    end
    if (!seen) w = -1;
    check(tag, w, exp_wait);
  endtask

  task automatic expect_no_start(input int cycles, input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (a_start) seen = 1'b1;
    end
    check(tag, {31'd0, seen}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; en_b = 1'b0; clr = 1'b0; sv = 1'b0; pe = 1'b0; pe_b = 1'b0;
    sd = 16'h0000; ff = 12'd2047; pc = 7'(PKT_LEN_DEF);
    repeat (3) @(negedge clk);
    check("rst_start", {31'd0, a_start}, 32'd0);
    check("rst_data",  {16'd0, a_data},  32'h2D2D);
    check("rst_busy",  {31'd0, a_busy},  32'd0);
    check("rst_sent",  {16'd0, a_sent},  32'd0);
    check("rst_drop",  {16'd0, a_drop},  32'd0);
    check("rst_err",   {31'd0, a_err},   32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Frame 1: enable at k=0, start visible at k=100, payload still the init value.
    en = 1'b1;
    wait_start(1'b0, 150, 100, "first_start");
    check("payload_init", {16'd0, a_data}, 32'h2D2D);
    check("busy_start",   {31'd0, a_busy}, 32'd1);
    @(negedge clk);                                   // k=101
    check("start_one_cycle", {31'd0, a_start}, 32'd0);
    repeat (19) @(negedge clk);                       // k=120
    sv = 1'b1; sd = 16'h3235;
    @(negedge clk);
    sv = 1'b0;
    repeat (49) @(negedge clk);                       // k=170
    pe = 1'b1;
    @(negedge clk);                                   // k=171, GAP
    pe = 1'b0;
    check("sent_1",       {16'd0, a_sent}, 32'd1);
    check("payload_held", {16'd0, a_data}, 32'h2D2D);
    repeat (11) @(negedge clk);                       // k=182
    check("gap_busy", {31'd0, a_busy}, 32'd1);
    @(negedge clk);                                   // k=183
    check("gap_end_idle", {31'd0, a_busy}, 32'd0);

    // Frame 2 carries the sample taken during frame 1; a mid-frame sample waits.
    wait_start(1'b0, 50, 17, "second_start");         // k=200
    check("payload_25", {16'd0, a_data}, 32'h3235);
    repeat (10) @(negedge clk);                       // k=210
    sv = 1'b1; sd = 16'h3236;
    @(negedge clk);
    sv = 1'b0;
    repeat (59) @(negedge clk);                       // k=270
    pe = 1'b1;
    @(negedge clk);
    pe = 1'b0;
    check("payload_mid_sample", {16'd0, a_data}, 32'h3235);
    check("sent_2",             {16'd0, a_sent}, 32'd2);
    wait_start(1'b0, 50, 29, "third_start");          // k=300
    check("payload_26", {16'd0, a_data}, 32'h3236);
    repeat (70) @(negedge clk);                       // k=370
    pe = 1'b1;
    @(negedge clk);
    pe = 1'b0;
    check("sent_3", {16'd0, a_sent}, 32'd3);
    check("drop_0", {16'd0, a_drop}, 32'd0);
    repeat (4) @(negedge clk);                        // k=375, GAP
    pe = 1'b1;
    @(negedge clk);
    pe = 1'b0;
    check("pkt_end_outside_send", {16'd0, a_sent}, 32'd3);

    // Insufficient FIFO space drops the slot; equality at the next slot passes.
    ff = 12'd40;
    repeat (24) @(negedge clk);                       // k=400
    check("no_space_start", {31'd0, a_start}, 32'd0);
    check("no_space_busy",  {31'd0, a_busy},  32'd0);
    check("no_space_drop",  {16'd0, a_drop},  32'd1);
    ff = 12'd64;
    repeat (99) @(negedge clk);                       // k=499, tick cycle
    sv = 1'b1; sd = 16'h3237;
    @(negedge clk);                                   // k=500
    sv = 1'b0;
    check("fifo_equal_start", {31'd0, a_start}, 32'd1);
    check("bypass_payload",   {16'd0, a_data},  32'h3237);

    // No packet end: timeout after 256 SEND cycles; two slots overrun meanwhile.
    repeat (256) @(negedge clk);                      // k=756
    check("timeout_not_yet", {31'd0, a_err},  32'd0);
    check("timeout_busy",    {31'd0, a_busy}, 32'd1);
    @(negedge clk);                                   // k=757
    check("timeout_err",     {31'd0, a_err},  32'd1);
    check("timeout_no_sent", {16'd0, a_sent}, 32'd3);
    check("timeout_overrun", {16'd0, a_drop}, 32'd3);
    wait_start(1'b0, 60, 43, "start_after_timeout");  // k=800
    repeat (70) @(negedge clk);                       // k=870
    pe = 1'b1; clr = 1'b1;
    @(negedge clk);
    pe = 1'b0; clr = 1'b0;
    check("clr_wins_sent", {16'd0, a_sent}, 32'd0);
    check("clr_drop",      {16'd0, a_drop}, 32'd0);
    check("clr_err",       {31'd0, a_err},  32'd0);

    // Disable mid-frame: the frame completes, no further starts.
    wait_start(1'b0, 50, 29, "start_before_disable"); // k=900
    repeat (5) @(negedge clk);
    en = 1'b0;
    repeat (65) @(negedge clk);                       // k=970
    pe = 1'b1;
    @(negedge clk);
    pe = 1'b0;
    check("sent_after_disable", {16'd0, a_sent}, 32'd1);
    expect_no_start(250, "no_start_disabled");

    // Reset in SEND returns outputs immediately; a late packet end is ignored.
    en = 1'b1;
    wait_start(1'b0, 150, 100, "reenable_start");
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    check("async_rst_busy", {31'd0, a_busy}, 32'd0);
    check("async_rst_sent", {16'd0, a_sent}, 32'd0);
    check("async_rst_data", {16'd0, a_data}, 32'h2D2D);
    en = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    pe = 1'b1;
    @(negedge clk);
    pe = 1'b0;
    check("late_end_ignored", {16'd0, a_sent}, 32'd0);
    check("late_end_idle",    {31'd0, a_busy}, 32'd0);
    en = 1'b1;
    wait_start(1'b0, 150, 100, "start_after_rst");
    check("shadow_reset", {16'd0, a_data}, 32'h2D2D);

    // Period 50 with 70-cycle frames: every other slot overruns.
    en_b = 1'b1;
    wait_start(1'b1, 80, 50, "b_first_start");
    repeat (70) @(negedge clk);
    pe_b = 1'b1;
    @(negedge clk);                                   // k'=121
    pe_b = 1'b0;
    check("b_overrun_drop_1", {16'd0, b_drop}, 32'd1);
    check("b_sent_1",         {16'd0, b_sent}, 32'd1);
    wait_start(1'b1, 60, 29, "b_second_start");       // k'=150
    repeat (70) @(negedge clk);
    pe_b = 1'b1;
    @(negedge clk);
    pe_b = 1'b0;
    check("b_overrun_drop_2", {16'd0, b_drop}, 32'd2);
    check("b_sent_2",         {16'd0, b_sent}, 32'd2);
    wait_start(1'b1, 60, 29, "b_third_start");        // k'=250

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
